// File: rtl/rsnn_pkg.sv
// Shared definitions for the RSNN core: loader command bytes, loader FSM
// states and the weight-memory depth shared with the core.
package rsnn_pkg;

    localparam int unsigned NUM_WEIGHTS_DEFAULT = 64;

    localparam logic [7:0] CMD_WRITE = 8'hA5;
    localparam logic [7:0] CMD_DONE  = 8'h5A;
    localparam logic [7:0] CMD_CLR   = 8'hC3;

    typedef enum logic [1:0] {
        StIdle,
        StGetAddr,
        StGetCnt,
        StData
    } loader_state_e;

endpackage

// File: rtl/rsnn_weight_loader.sv
// Byte-serial configuration front end: parses WRITE/DONE/CLR frames and
// issues registered write beats to the weight memory.
module rsnn_weight_loader
    import rsnn_pkg::*;
#(
    parameter int unsigned NUM_WEIGHTS = NUM_WEIGHTS_DEFAULT,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_WEIGHTS),
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  abort,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  err
);

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            rem_q, rem_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cfg_done_q, cfg_done_d;
    logic                  err_q, err_d;

    // Next-state: interpret at most one byte per cycle; abort overrides it.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cfg_done_d  = cfg_done_q;
        err_d       = err_q;

        if (abort) begin
            state_d = StIdle;
        end else if (in_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (in_data == CMD_WRITE) begin
                        cfg_done_d = 1'b0;
                        state_d    = StGetAddr;
                    end else if (in_data == CMD_DONE) begin
                        cfg_done_d = 1'b1;
                    end else if (in_data == CMD_CLR) begin
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StGetAddr: begin
                    addr_d  = in_data[ADDR_WIDTH-1:0];
                    state_d = StGetCnt;
                end
                StGetCnt: begin
                    if (in_data == 8'd0) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        rem_d   = in_data;
                        state_d = StData;
                    end
                end
                StData: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data[DATA_WIDTH-1:0];
                    addr_d      = addr_q + 1'b1;
                    rem_d       = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cfg_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cfg_done_q  <= cfg_done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle);
    assign cfg_done  = cfg_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rsnn_weight_loader.sv
// Scoreboard bench for rsnn_weight_loader: expected write beats are queued as
// stimulus is issued; a negedge monitor pops and compares each mem_we beat.
module tb_rsnn_weight_loader;
    import rsnn_pkg::*;

    localparam int unsigned NW = 64;
    localparam int unsigned AW = 6;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          abort;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          cfg_done;
    logic          err;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    rsnn_weight_loader #(
        .NUM_WEIGHTS(NW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .abort    (abort),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .cfg_done (cfg_done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; the byte is taken on the next edge.
    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [AW-1:0] a, input logic [7:0] d);
        beat_t b;
        b.addr = a;
        b.data = d;
        exp_q.push_back(b);
    endtask

    // Monitor: every write beat must match the head of the scoreboard.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none",
                             mem_addr, mem_wdata);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_addr", int'(mem_addr), int'(b.addr));
                    check("beat_data", int'(mem_wdata), int'(b.data));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of run, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        abort    = 1'b0;
        idle(3);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_cfg_done", int'(cfg_done), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        rst_n = 1'b1;
        idle(1);

        // Reset mid-frame discards the partial frame.
        send(CMD_WRITE);
        send(8'h10);
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("midrst_busy", int'(busy), 0);
        send(8'h3F);
        check("midrst_unknown_err", int'(err), 1);
        check("midrst_busy2", int'(busy), 0);
        send(CMD_CLR);
        check("clr_err", int'(err), 0);

        // Basic write with gaps.
        send(CMD_WRITE);
        idle(2);
        send(8'h04);
        send(8'h03);
        expect_beat(6'd4, 8'h11);
        expect_beat(6'd5, 8'h22);
        expect_beat(6'd6, 8'h33);
        send(8'h11);
        idle(1);
        send(8'h22);
        idle(3);
        check("basic_busy_mid", int'(busy), 1);
        send(8'h33);
        check("basic_busy_end", int'(busy), 0);
        idle(2);
        check("hold_addr", int'(mem_addr), 6);
        check("hold_data", int'(mem_wdata), 8'h33);

        // Address wrap and address byte taken modulo 64.
        send(CMD_WRITE);
        send(8'h3E);
        send(8'h03);
        expect_beat(6'd62, 8'hAA);
        expect_beat(6'd63, 8'hBB);
        expect_beat(6'd0, 8'hCC);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(CMD_WRITE);
        send(8'h45);
        send(8'h01);
        expect_beat(6'd5, 8'h77);
        send(8'h77);
        idle(1);

        // Zero count is a framing error; CLR clears, unknown byte sets.
        send(CMD_WRITE);
        send(8'h00);
        send(8'h00);
        check("zero_err", int'(err), 1);
        check("zero_busy", int'(busy), 0);
        send(CMD_CLR);
        check("zero_clr", int'(err), 0);
        send(8'h12);
        check("unk_err", int'(err), 1);
        send(CMD_CLR);

        // Abort wins over a simultaneous data byte.
        send(CMD_WRITE);
        send(8'h00);
        send(8'h05);
        expect_beat(6'd0, 8'h01);
        expect_beat(6'd1, 8'h02);
        send(8'h01);
        send(8'h02);
        abort = 1'b1;
        send(8'h03);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_err", int'(err), 0);
        send(CMD_WRITE);
        send(8'h08);
        send(8'h01);
        expect_beat(6'd8, 8'h09);
        send(8'h09);

        // Done handling.
        send(CMD_DONE);
        check("done_set", int'(cfg_done), 1);
        idle(4);
        check("done_hold", int'(cfg_done), 1);
        send(CMD_WRITE);
        check("done_clr", int'(cfg_done), 0);
        send(8'h10);
        send(8'h01);
        expect_beat(6'd16, 8'hEE);
        send(8'hEE);

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
